pwm_multi_ctrl: RTL and testbench

Parametrised successor of the single-channel button-controlled PWM generator. It drives NCH independent PWM channels from one shared period counter. Each channel's duty is adjusted by debounced increase/decrease buttons, addressed via a channel select. Duty updates are shadowed and take effect only at the period boundary, so outputs are glitch-free. Sits between the top-level ui_in pins and uo_out.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/btn_debounce.sv | 19 +
 rtl/pwm_multi_ctrl.sv | 73 +++++++
 tb/tb_pwm_multi_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, debounce divider constants and the saturating duty step helper.
package pwm_pkg;
  localparam int CNT_W_DEF    = 8;
  localparam int DEB_DIV_FPGA = 25_000_000;
  localparam int DEB_DIV_SIM  = 2;
  typedef enum logic {DIR_DEC = 1'b0, DIR_INC = 1'b1} dir_e;
  function automatic int unsigned sat_add_sub(input int unsigned value, input int unsigned step,
                                              input int unsigned limit, input dir_e dir);
    return (dir == DIR_INC) ? ((value + step > limit) ? limit : value + step)
                            : ((value < step) ? 0 : value - step);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: tick-sampled two-stage button filter producing one press pulse per rising edge.
module btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic press
);
  logic q1, q2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else if (tick) begin
      q1 <= btn;
      q2 <= q1;
    end
  assign press = q1 & ~q2 & tick;
endmodule

// File: rtl/pwm_multi_ctrl.sv
// pwm_multi_ctrl: NCH PWM channels on one shared period counter with button-adjusted shadowed duties.
// Define PWM_PHASE_STAGGER_EN to offset each channel's compare phase by i*(PERIOD/NCH).
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PERIOD    = 10,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5,
  parameter int DEB_DIV   = DEB_DIV_FPGA,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             inc_btn,
  input  logic             dec_btn,
  input  logic [SW-1:0]    ch_sel,
  output logic [NCH-1:0]   pwm_out,
  output logic             period_start,
  output logic [CNT_W-1:0] duty_sel
);
  logic [PW-1:0] pre;
  logic tick, inc_p, dec_p, do_inc, do_dec, sel_ok, wrap;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow [NCH];
  logic [CNT_W-1:0] active [NCH];
  logic [NCH-1:0] hit;
  assign tick = (pre == PW'(DEB_DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  btn_debounce u_inc (.clk(clk), .rst_n(rst_n), .tick(tick), .btn(inc_btn), .press(inc_p));
  btn_debounce u_dec (.clk(clk), .rst_n(rst_n), .tick(tick), .btn(dec_btn), .press(dec_p));
  assign do_inc = inc_p & ~dec_p;
  assign do_dec = dec_p & ~inc_p;
  assign sel_ok = int'(ch_sel) < NCH;
  assign wrap   = ena && (cnt == CNT_W'(PERIOD - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= CNT_W'(DUTY_INIT);
        active[i] <= CNT_W'(DUTY_INIT);
      end
    end else begin
      if ((do_inc | do_dec) && sel_ok)
        shadow[ch_sel] <= CNT_W'(sat_add_sub(32'(shadow[ch_sel]), STEP, PERIOD, do_inc ? DIR_INC : DIR_DEC));
      if (wrap) active <= shadow;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (ena) cnt <= wrap ? '0 : cnt + 1'b1;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cmp;
`ifdef PWM_PHASE_STAGGER_EN
    assign cmp = CNT_W'((32'(cnt) + i * (PERIOD / NCH)) % PERIOD);
`else
    assign cmp = cnt;
`endif
    assign hit[i] = cmp < active[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= ena ? hit : '0;
      period_start <= ena & (cnt == '0);
    end
  assign duty_sel = sel_ok ? shadow[ch_sel] : '0;
endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// tb_pwm_multi_ctrl: directed checks of duty shadowing, saturation, pause/resume, reset and phase.
module tb_pwm_multi_ctrl;
  logic clk = 0, rst_n = 0, ena = 0, inc_btn = 0, dec_btn = 0, inc2 = 0, dec2 = 0;
  logic [1:0] ch_sel = 0, ch_sel2 = 0;
  logic [3:0] pwm_out;
  logic [2:0] pwm_out2;
  logic period_start, ps2;
  logic [7:0] duty_sel, duty_sel2;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  pwm_multi_ctrl #(.NCH(4), .CNT_W(8), .PERIOD(10), .STEP(1), .DUTY_INIT(5), .DEB_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .inc_btn(inc_btn), .dec_btn(dec_btn), .ch_sel(ch_sel),
    .pwm_out(pwm_out), .period_start(period_start), .duty_sel(duty_sel));

  pwm_multi_ctrl #(.NCH(3), .CNT_W(8), .PERIOD(10), .STEP(1), .DUTY_INIT(5), .DEB_DIV(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .inc_btn(inc2), .dec_btn(dec2), .ch_sel(ch_sel2),
    .pwm_out(pwm_out2), .period_start(ps2), .duty_sel(duty_sel2));

  task automatic press(input logic i, input logic d);
    @(negedge clk);
    inc_btn = i;
    dec_btn = d;
    repeat (12) @(negedge clk);
    inc_btn = 0;
    dec_btn = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic sync;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 40);
    checks++;
    if (period_start !== 1'b1) begin
      fails++;
      $display("FAIL sync: period_start=%b, wanted 1 within 40 clocks", period_start);
    end
  endtask

  task automatic window(output int hi[4], output int ps);
    hi = '{default: 0};
    ps = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
      ps += int'(period_start);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (pwm_out !== 4'h0 || period_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: pwm_out=%h period_start=%b, wanted 0 0", pwm_out, period_start);
    end
    checks++;
    if (duty_sel !== 8'd5) begin
      fails++;
      $display("FAIL reset_duty: duty_sel=%0d, wanted 5", duty_sel);
    end
    rst_n = 1;
  endtask

  task automatic test_steady;
    int hi[4];
    int ps;
    @(negedge clk);
    ena = 1;
    hi = '{default: 0};
    ps = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
      ps += int'(period_start);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi[c] != 15) begin
        fails++;
        $display("FAIL steady_ch%0d: high %0d of 30 clocks, wanted 15", c, hi[c]);
      end
    end
    checks++;
    if (ps != 3) begin
      fails++;
      $display("FAIL steady_ps: %0d period_start pulses, wanted 3", ps);
    end
  endtask

  task automatic test_shadow;
    int hi[4];
    int ps;
    ch_sel = 2;
    sync();
    inc_btn = 1;
    window(hi, ps);
    checks++;
    if (hi[2] != 5) begin
      fails++;
      $display("FAIL shadow_hold: ch2 high %0d, wanted 5", hi[2]);
    end
    checks++;
    if (duty_sel !== 8'd6) begin
      fails++;
      $display("FAIL shadow_read: duty_sel=%0d, wanted 6", duty_sel);
    end
    @(negedge clk);
    window(hi, ps);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi[c] != ((c == 2) ? 6 : 5)) begin
        fails++;
        $display("FAIL shadow_apply_ch%0d: high %0d, wanted %0d", c, hi[c], (c == 2) ? 6 : 5);
      end
    end
    inc_btn = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (duty_sel !== 8'd6) begin
      fails++;
      $display("FAIL one_press: duty_sel=%0d, wanted 6", duty_sel);
    end
  endtask

  task automatic test_saturate;
    int hi[4];
    int ps;
    ch_sel = 0;
    repeat (7) press(0, 1);
    checks++;
    if (duty_sel !== 8'd0) begin
      fails++;
      $display("FAIL sat_low: duty_sel=%0d, wanted 0", duty_sel);
    end
    sync();
    window(hi, ps);
    checks++;
    if (hi[0] != 0 || hi[2] != 6) begin
      fails++;
      $display("FAIL sat_low_out: ch0 high %0d ch2 high %0d, wanted 0 and 6", hi[0], hi[2]);
    end
    repeat (12) press(1, 0);
    checks++;
    if (duty_sel !== 8'd10) begin
      fails++;
      $display("FAIL sat_high: duty_sel=%0d, wanted 10", duty_sel);
    end
    sync();
    window(hi, ps);
    checks++;
    if (hi[0] != 10) begin
      fails++;
      $display("FAIL sat_high_out: ch0 high %0d, wanted 10", hi[0]);
    end
  endtask

  task automatic test_no_change;
    logic [7:0] exp_d [4];
    exp_d = '{8'd10, 8'd5, 8'd6, 8'd5};
    ch_sel = 1;
    press(1, 1);
    for (int c = 0; c < 4; c++) begin
      ch_sel = 2'(c);
      #1;
      checks++;
      if (duty_sel !== exp_d[c]) begin
        fails++;
        $display("FAIL both_btn_ch%0d: duty_sel=%0d, wanted %0d", c, duty_sel, exp_d[c]);
      end
    end
    ch_sel2 = 3;
    @(negedge clk);
    inc2 = 1;
    repeat (12) @(negedge clk);
    inc2 = 0;
    repeat (8) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      ch_sel2 = 2'(c);
      #1;
      checks++;
      if (duty_sel2 !== 8'd5) begin
        fails++;
        $display("FAIL bad_sel_ch%0d: duty_sel=%0d, wanted 5", c, duty_sel2);
      end
    end
    ch_sel2 = 1;
    @(negedge clk);
    inc2 = 1;
    repeat (12) @(negedge clk);
    inc2 = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (duty_sel2 !== 8'd6) begin
      fails++;
      $display("FAIL valid_sel: duty_sel=%0d, wanted 6", duty_sel2);
    end
  endtask

  task automatic test_pause;
    logic [3:0] ep;
    do_reset();
    sync();
    repeat (2) @(negedge clk);
    ena = 0;
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 4'h0 || period_start !== 1'b0) begin
        fails++;
        $display("FAIL pause_%0d: pwm_out=%h period_start=%b, wanted 0 0", s, pwm_out, period_start);
      end
    end
    ena = 1;
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      ep = (s <= 2 || s == 8) ? 4'hF : 4'h0;
      checks++;
      if (pwm_out !== ep || period_start !== (s == 8)) begin
        fails++;
        $display("FAIL resume_%0d: pwm_out=%h period_start=%b, wanted %h %b", s, pwm_out, period_start, ep, s == 8);
      end
    end
    ch_sel = 1;
    press(1, 0);
    checks++;
    if (duty_sel !== 8'd6) begin
      fails++;
      $display("FAIL pre_reset_duty: duty_sel=%0d, wanted 6", duty_sel);
    end
    sync();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (pwm_out !== 4'h0 || period_start !== 1'b0) begin
      fails++;
      $display("FAIL async_clear: pwm_out=%h period_start=%b, wanted 0 0", pwm_out, period_start);
    end
    checks++;
    if (duty_sel !== 8'd5) begin
      fails++;
      $display("FAIL reset_duty_restore: duty_sel=%0d, wanted 5", duty_sel);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_phase;
    logic [3:0] e;
    sync();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      for (int c = 0; c < 4; c++)
`ifdef PWM_PHASE_STAGGER_EN
        e[c] = ((k + 2 * c) % 10) < 5;
`else
        e[c] = k < 5;
`endif
      checks++;
      if (pwm_out !== e) begin
        fails++;
        $display("FAIL phase_cnt%0d: pwm_out=%b, wanted %b", k, pwm_out, e);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_steady();
    test_shadow();
    test_saturate();
    test_no_change();
    test_pause();
    test_phase();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
